// File: rtl/apb_master_bridge.sv
// APB master bridge: turns a single CPU register request into one APB SETUP/ACCESS transfer.
// Optional ACCESS-phase timeout is compiled in when APB_TIMEOUT_EN is defined.
module apb_master_bridge #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DEV_W   = 4,
  parameter int unsigned NUM_DEV = 4
`ifdef APB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  // CPU side
  input  logic              i_apb_req,
  input  logic              i_apb_write,
  input  logic [ADDR_W-1:0] i_apb_addr,
  input  logic [DATA_W-1:0] i_apb_data,
  input  logic [DEV_W-1:0]  i_apb_device,
  output logic              o_ready,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_err,
  // APB side
  output logic [NUM_DEV-1:0] o_psel,
  output logic               o_penable,
  output logic               o_pwrite,
  output logic [ADDR_W-1:0]  o_paddr,
  output logic [DATA_W-1:0]  o_pwdata,
  input  logic [DATA_W-1:0]  i_prdata,
  input  logic               i_pready,
  input  logic               i_pslverr
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e              r_state, w_state;
  logic                r_write, w_write;
  logic [ADDR_W-1:0]   r_addr,  w_addr;
  logic [DATA_W-1:0]   r_wdata, w_wdata;
  logic [DATA_W-1:0]   r_rdata, w_rdata;
  logic [NUM_DEV-1:0]  r_sel,   w_sel;
  logic                r_done,  w_done;
  logic                r_err,   w_err;
  logic [NUM_DEV-1:0]  w_dec;
  logic                w_dev_ok;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CntW-1:0] r_cnt, w_cnt;
  logic            w_expire;

  // Expiry only on a no-ready cycle, so a late pready on the last cycle still completes normally.
  assign w_expire = (r_cnt == CntW'(TIMEOUT_CYCLES - 1)) && !i_pready;
`endif

  always_comb begin
    w_dec    = '0;
    w_dev_ok = 32'(i_apb_device) < NUM_DEV;
    for (int unsigned i = 0; i < NUM_DEV; i++) begin
      w_dec[i] = (32'(i_apb_device) == i);
    end
  end

  always_comb begin
    w_state = r_state;
    w_write = r_write;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_rdata = r_rdata;
    w_sel   = r_sel;
    w_done  = 1'b0;
    w_err   = 1'b0;
`ifdef APB_TIMEOUT_EN
    w_cnt   = r_cnt;
`endif
    unique case (r_state)
      StIdle: begin
        if (i_apb_req) begin
          // Bus-facing regs only move for a decodable device so the bus stays quiet on errors.
          if (w_dev_ok) begin
            w_write = i_apb_write;
            w_addr  = i_apb_addr;
            w_wdata = i_apb_data;
            w_sel   = w_dec;
            w_state = StSetup;
          end else begin
            w_done = 1'b1;
            w_err  = 1'b1;
          end
        end
      end
      StSetup: begin
        w_state = StAccess;
`ifdef APB_TIMEOUT_EN
        w_cnt   = '0;
`endif
      end
      StAccess: begin
        if (i_pready) begin
          w_state = StIdle;
          w_done  = 1'b1;
          w_err   = i_pslverr;
          if (!r_write) begin
            w_rdata = i_prdata;
          end
        end
`ifdef APB_TIMEOUT_EN
        else if (w_expire) begin
          w_state = StIdle;
          w_done  = 1'b1;
          w_err   = 1'b1;
        end else begin
          w_cnt = r_cnt + CntW'(1);
        end
`endif
      end
      default: w_state = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_sel   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      r_cnt   <= '0;
`endif
    end else begin
      r_state <= w_state;
      r_write <= w_write;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_rdata <= w_rdata;
      r_sel   <= w_sel;
      r_done  <= w_done;
      r_err   <= w_err;
`ifdef APB_TIMEOUT_EN
      r_cnt   <= w_cnt;
`endif
    end
  end

  assign o_ready   = (r_state == StIdle);
  assign o_done    = r_done;
  assign o_err     = r_err;
  assign o_rdata   = r_rdata;
  assign o_psel    = (r_state == StIdle) ? '0 : r_sel;
  assign o_penable = (r_state == StAccess);
  assign o_pwrite  = r_write;
  assign o_paddr   = r_addr;
  assign o_pwdata  = r_wdata;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed table, hand-written corner sequences and random transfers
// checked cycle by cycle against a transaction-level timeline model.
module tb_apb_master_bridge;

  localparam int unsigned NumDev = 4;

  logic       clk = 1'b0;
  logic       rst_n, apb_req, apb_write;
  logic [7:0] apb_addr, apb_data, rdata, paddr, pwdata, prdata;
  logic [3:0] apb_device, psel;
  logic       ready, done, err, penable, pwrite, pready, pslverr;

  always #5 clk = ~clk;

  apb_master_bridge dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_apb_req   (apb_req),
    .i_apb_write (apb_write),
    .i_apb_addr  (apb_addr),
    .i_apb_data  (apb_data),
    .i_apb_device(apb_device),
    .o_ready     (ready),
    .o_done      (done),
    .o_rdata     (rdata),
    .o_err       (err),
    .o_psel      (psel),
    .o_penable   (penable),
    .o_pwrite    (pwrite),
    .o_paddr     (paddr),
    .o_pwdata    (pwdata),
    .i_prdata    (prdata),
    .i_pready    (pready),
    .i_pslverr   (pslverr)
  );

  typedef struct {
    bit         write;
    logic [7:0] addr;
    logic [7:0] data;
    logic [3:0] dev;
    int         waits;
    logic [7:0] prd;
    bit         slverr;
    bit         exp_err;
    logic [7:0] exp_rdata;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  m_rdata;
  logic [16:0] m_bus;
  vec_t        tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] onehot(input logic [3:0] d);
    return 4'd1 << d;
  endfunction

  // Starts just after a rising edge; returns just after the edge that ends the done cycle.
  task automatic run_txn(input vec_t v);
    bit         dec_err;
    int         last;
    logic [3:0] exp_psel;
    bit         exp_pen;
    dec_err    = (v.dev >= NumDev);
    last       = dec_err ? 1 : 3 + v.waits;
    apb_req    = 1'b1;
    apb_write  = v.write;
    apb_addr   = v.addr;
    apb_data   = v.data;
    apb_device = v.dev;
    for (int t = 0; t <= last; t++) begin
      if (t >= 1) apb_req = 1'b0;
      pready  = !dec_err && (t == 2 + v.waits);
      prdata  = pready ? v.prd : 8'($urandom);
      pslverr = pready ? v.slverr : 1'($urandom);
      @(negedge clk);
      exp_psel = (!dec_err && t >= 1 && t <= 2 + v.waits) ? onehot(v.dev) : 4'b0;
      exp_pen  = !dec_err && t >= 2 && t <= 2 + v.waits;
      check("bus_ctl", {psel, penable, ready, done},
            {exp_psel, exp_pen, (t == 0 || t == last), (t == last)});
      if (exp_psel != 4'b0) check("bus_fields", {pwrite, paddr, pwdata}, {v.write, v.addr, v.data});
      if (t == last) begin
        check("err", err, v.exp_err);
        check("rdata", rdata, v.exp_rdata);
        if (!dec_err) m_bus = {v.write, v.addr, v.data};
        check("idle_hold", {pwrite, paddr, pwdata}, m_bus);
      end
      @(posedge clk);
      #1;
    end
    m_rdata = v.exp_rdata;
    pready  = 1'b0;
    pslverr = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    tbl[0] = '{write:1, addr:8'h1F, data:8'h01, dev:4'd1, waits:0, prd:8'h00, slverr:0,
               exp_err:0, exp_rdata:8'h00};
    tbl[1] = '{write:0, addr:8'h1E, data:8'h00, dev:4'd0, waits:3, prd:8'h1F, slverr:0,
               exp_err:0, exp_rdata:8'h1F};
    tbl[2] = '{write:0, addr:8'h10, data:8'h00, dev:4'hA, waits:0, prd:8'h77, slverr:0,
               exp_err:1, exp_rdata:8'h1F};
    tbl[3] = '{write:1, addr:8'h22, data:8'h5A, dev:4'd2, waits:0, prd:8'h00, slverr:1,
               exp_err:1, exp_rdata:8'h1F};
    tbl[4] = '{write:0, addr:8'h30, data:8'h00, dev:4'd3, waits:1, prd:8'hA5, slverr:1,
               exp_err:1, exp_rdata:8'hA5};
    tbl[5] = '{write:0, addr:8'h31, data:8'h00, dev:4'd2, waits:2, prd:8'h3C, slverr:0,
               exp_err:0, exp_rdata:8'h3C};
    tbl[6] = '{write:1, addr:8'h40, data:8'h99, dev:4'd4, waits:0, prd:8'h00, slverr:0,
               exp_err:1, exp_rdata:8'h3C};
    tbl[7] = '{write:0, addr:8'hFF, data:8'h00, dev:4'd3, waits:0, prd:8'h00, slverr:0,
               exp_err:0, exp_rdata:8'h00};
    tbl[8] = '{write:1, addr:8'h01, data:8'hFF, dev:4'd0, waits:4, prd:8'hEE, slverr:0,
               exp_err:0, exp_rdata:8'h00};

    rst_n = 1'b0; apb_req = 1'b0; apb_write = 1'b0; apb_addr = '0; apb_data = '0;
    apb_device = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    m_rdata = '0; m_bus = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_ctl", {ready, done, err, penable, psel}, {1'b1, 1'b0, 1'b0, 1'b0, 4'b0});
    check("reset_data", {rdata, pwrite, paddr, pwdata}, 32'd0);
    @(posedge clk);
    #1;

    foreach (tbl[i]) run_txn(tbl[i]);

    // Back-to-back writes with apb_req held high: a done every third cycle.
    begin
      logic [3:0] devs[3];
      logic [7:0] adrs[3];
      logic [7:0] dats[3];
      int         k;
      int         ph;
      devs = '{4'd1, 4'd3, 4'd0};
      adrs = '{8'h11, 8'h22, 8'h33};
      dats = '{8'hC1, 8'hC2, 8'hC3};
      pready = 1'b1;
      for (int c = 0; c <= 9; c++) begin
        k  = (c < 9) ? c / 3 : 2;
        ph = c % 3;
        apb_req = (c < 9);
        if (c < 9) begin
          apb_write = 1'b1; apb_addr = adrs[k]; apb_data = dats[k]; apb_device = devs[k];
        end
        @(negedge clk);
        check("b2b_ctl", {psel, penable, ready, done},
              {(c < 9 && ph != 0) ? onehot(devs[k]) : 4'b0, (c < 9 && ph == 2), (ph == 0),
               (c > 0 && ph == 0)});
        if (c < 9 && ph != 0) check("b2b_fields", {pwrite, paddr, pwdata}, {1'b1, adrs[k], dats[k]});
        if (c > 0 && ph == 0) check("b2b_err", err, 1'b0);
        @(posedge clk);
        #1;
      end
      apb_req = 1'b0;
      pready  = 1'b0;
      m_bus   = {1'b1, adrs[2], dats[2]};
    end

    // Reset while in ACCESS: everything drops, no done pulse follows.
    apb_req = 1'b1; apb_write = 1'b0; apb_addr = 8'h33; apb_data = 8'h44; apb_device = 4'd2;
    pready = 1'b0;
    @(posedge clk);
    #1 apb_req = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_pre", {psel, penable}, {4'b0100, 1'b1});
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    pready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_abort", {psel, penable, ready, done}, {4'b0, 1'b0, 1'b1, 1'b0});
      @(posedge clk);
      #1;
    end
    check("rst_rdata", rdata, 8'h00);
    pready = 1'b0;
    m_rdata = '0;
    m_bus = '0;

    // Random transfers; expectations come from the transaction rules, not the cycle mechanics.
    for (int n = 0; n < 40; n++) begin
      v.write  = 1'($urandom);
      v.addr   = 8'($urandom);
      v.data   = 8'($urandom);
      v.dev    = 4'($urandom_range(0, 6));
      v.waits  = $urandom_range(0, 4);
      v.prd    = 8'($urandom);
      v.slverr = ($urandom_range(0, 3) == 0);
      v.exp_err   = (v.dev >= NumDev) || v.slverr;
      v.exp_rdata = (v.dev >= NumDev || v.write) ? m_rdata : v.prd;
      run_txn(v);
    end

`ifdef APB_TIMEOUT_EN
    // Slave never ready: abort with error after 16 ACCESS cycles.
    apb_req = 1'b1; apb_write = 1'b0; apb_addr = 8'h5E; apb_data = 8'h6F; apb_device = 4'd1;
    pready = 1'b0;
    for (int c = 0; c <= 18; c++) begin
      if (c >= 1) apb_req = 1'b0;
      prdata = 8'($urandom);
      @(negedge clk);
      check("tmo_ctl", {psel, penable, ready, done},
            {(c >= 1 && c <= 17) ? 4'b0010 : 4'b0, (c >= 2 && c <= 17), (c == 0 || c == 18),
             (c == 18)});
      if (c == 18) begin
        check("tmo_err", err, 1'b1);
        check("tmo_rdata", rdata, m_rdata);
      end
      @(posedge clk);
      #1;
    end
    m_bus = {1'b0, 8'h5E, 8'h6F};
    v = '{write:0, addr:8'h61, data:8'h00, dev:4'd1, waits:15, prd:8'h6B, slverr:0,
          exp_err:0, exp_rdata:8'h6B};
    run_txn(v);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
